// File: rtl/bch_31_decoder.sv
// BCH(31,21) double-error correction stage: Peterson t=2 locator solve plus a
// serial Chien search, one bit position per cycle, valid/ready on both sides.
// Optional build macro: BCH31_SYN_CHECK_EN -- also registers S2/S4 and flags the
// word uncorrectable when S2 != S1^2 or S4 != S2^2 (corrupt syndrome delivery).
module bch_31_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] codeword,
  input  logic [4:0]  S1,
  input  logic [4:0]  S2,
  input  logic [4:0]  S3,
  input  logic [4:0]  S4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] corrected,
  output logic [1:0]  nerr,
  output logic        uncorr
);

  typedef enum logic [1:0] {IDLE = 2'd0, SOLVE = 2'd1, SEARCH = 2'd2, DONE = 2'd3} state_t;

  // GF(2^5), x^5 = x^2 + 1: multiply by alpha
  function automatic logic [4:0] gf_mul_alpha(input logic [4:0] a);
    return {a[3:0], 1'b0} ^ (a[4] ? 5'b00101 : 5'b00000);
  endfunction

  // multiply by alpha^-1 (alpha^-1 = 5'b10010)
  function automatic logic [4:0] gf_div_alpha(input logic [4:0] a);
    return {1'b0, a[4:1]} ^ (a[0] ? 5'b10010 : 5'b00000);
  endfunction

  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] acc;
    logic [4:0] aa;
    acc = 5'd0;
    aa  = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) acc = acc ^ aa;
      else      acc = acc;
      aa = gf_mul_alpha(aa);
    end
    return acc;
  endfunction

  function automatic logic [4:0] gf_sq(input logic [4:0] a);
    return gf_mul(a, a);
  endfunction

  // inverse as a^30 = a^16 * a^8 * a^4 * a^2
  function automatic logic [4:0] gf_inv(input logic [4:0] a);
    logic [4:0] a2, a4, a8, a16;
    a2  = gf_sq(a);
    a4  = gf_sq(a2);
    a8  = gf_sq(a4);
    a16 = gf_sq(a8);
    return gf_mul(gf_mul(a16, a8), gf_mul(a4, a2));
  endfunction

  state_t      state_r, state_nx_s;
  logic [30:0] cw_r, work_r, work_nx_s;
  logic [4:0]  s1_r, s3_r, t1_r, t2_r, idx_r;
  logic [1:0]  deg_r, cnt_r, cnt_nx_s, deg_s;
  logic        pre_r, pre_s, pre_chk_s, root_s, fin_unc_s;
  logic [4:0]  s1_cube_s, sig1_s, sig2_s, eval_s;

`ifdef BCH31_SYN_CHECK_EN
  logic [4:0]  s2_r, s4_r;
`else
  logic        unused_syn_s;
  assign unused_syn_s = ^{S2, S4};
`endif

  // next-state logic of the control FSM
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (in_valid && in_ready) state_nx_s = SOLVE;
               else                      state_nx_s = IDLE;
      SOLVE:   state_nx_s = SEARCH;
      SEARCH:  if (idx_r == 5'd30) state_nx_s = DONE;
               else                state_nx_s = SEARCH;
      DONE:    if (out_ready) state_nx_s = IDLE;
               else           state_nx_s = DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // state register and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      in_ready  <= (state_nx_s == IDLE);
      out_valid <= (state_nx_s == DONE);
    end
  end

  // Peterson t=2 solve of the error locator from S1 and S3
  always_comb begin
    s1_cube_s = gf_mul(gf_sq(s1_r), s1_r);
    sig1_s    = 5'd0;
    sig2_s    = 5'd0;
    deg_s     = 2'd0;
    pre_s     = 1'b0;
    pre_chk_s = 1'b0;
    if (s1_r == 5'd0) begin
      pre_s = (s3_r != 5'd0);
    end else if (s1_cube_s == s3_r) begin
      sig1_s = s1_r;
      deg_s  = 2'd1;
    end else begin
      sig1_s = s1_r;
      sig2_s = gf_mul(s3_r ^ s1_cube_s, gf_inv(s1_r));
      deg_s  = 2'd2;
    end
`ifdef BCH31_SYN_CHECK_EN
    if ((s2_r != gf_sq(s1_r)) || (s4_r != gf_sq(s2_r))) pre_chk_s = 1'b1;
    else                                                   pre_chk_s = 1'b0;
`endif
    pre_s = pre_s | pre_chk_s;
  end

  // Chien step: evaluate sigma(alpha^-idx) and apply the flip / root count
  always_comb begin
    eval_s    = 5'd1 ^ t1_r ^ t2_r;
    root_s    = (eval_s == 5'd0);
    work_nx_s = work_r;
    cnt_nx_s  = cnt_r;
    if (root_s) begin
      work_nx_s = work_r ^ (31'd1 << idx_r);
      cnt_nx_s  = (cnt_r == 2'd3) ? 2'd3 : cnt_r + 2'd1;
    end else begin
      work_nx_s = work_r;
      cnt_nx_s  = cnt_r;
    end
    fin_unc_s = pre_r | (cnt_nx_s != deg_r);
  end

  // datapath: capture, solve, serial search and final result write
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_r      <= 31'd0;
      work_r    <= 31'd0;
      s1_r      <= 5'd0;
      s3_r      <= 5'd0;
      t1_r      <= 5'd0;
      t2_r      <= 5'd0;
      idx_r     <= 5'd0;
      deg_r     <= 2'd0;
      cnt_r     <= 2'd0;
      pre_r     <= 1'b0;
      corrected <= 31'd0;
      nerr      <= 2'd0;
      uncorr    <= 1'b0;
`ifdef BCH31_SYN_CHECK_EN
      s2_r      <= 5'd0;
      s4_r      <= 5'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            cw_r   <= codeword;
            work_r <= codeword;
            s1_r   <= S1;
            s3_r   <= S3;
`ifdef BCH31_SYN_CHECK_EN
            s2_r   <= S2;
            s4_r   <= S4;
`endif
          end
        end
        SOLVE: begin
          t1_r  <= sig1_s;
          t2_r  <= sig2_s;
          deg_r <= deg_s;
          pre_r <= pre_s;
          cnt_r <= 2'd0;
          idx_r <= 5'd0;
        end
        SEARCH: begin
          t1_r   <= gf_div_alpha(t1_r);
          t2_r   <= gf_div_alpha(gf_div_alpha(t2_r));
          work_r <= work_nx_s;
          cnt_r  <= cnt_nx_s;
          if (idx_r == 5'd30) begin
            idx_r     <= 5'd0;
            corrected <= fin_unc_s ? cw_r : work_nx_s;
            nerr      <= fin_unc_s ? 2'd0 : cnt_nx_s;
            uncorr    <= fin_unc_s;
          end else begin
            idx_r <= idx_r + 5'd1;
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= 5'd0;
        end
      endcase
    end
  end

endmodule
